cart_loader: RTL and testbench

//  Sits between hps_io ioctl download and the cartridge ROM dpram / A2601top.

---
 rtl/a2600_cart_pkg.sv | 65 ++++++
 rtl/cart_ext_decode.sv | 31 +++
 rtl/cart_loader.sv | 183 ++++++++++++++++++
 tb/tb_cart_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2600_cart_pkg.sv
// Shared constants for the 2600 cartridge loader: bank-switch codes, FSM states,
// image-size thresholds and the lookup helpers used by the loader and ext decoder.
package a2600_cart_pkg;

    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;
    localparam logic [3:0] BS_P2   = 4'd7;
    localparam logic [3:0] BS_FA   = 4'd8;
    localparam logic [3:0] BS_CV   = 4'd9;

    localparam int NUM_BS = 9;

    localparam int SIZE_BITS = 17;
    typedef logic [SIZE_BITS-1:0] size_t;

    localparam size_t SIZE_8K  = 17'd8192;
    localparam size_t SIZE_12K = 17'd12288;
    localparam size_t SIZE_16K = 17'd16384;
    localparam size_t SIZE_32K = 17'd32768;
    localparam size_t SC_MIN_SIZE = SIZE_8K;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINAL,
        ST_READY
    } state_t;

    // Three-character extension (including the dot) that selects each scheme.
    function automatic logic [23:0] bs_ext(input logic [3:0] code);
        logic [23:0] e;
        case (code)
            BS_F8:   e = ".F8";
            BS_F6:   e = ".F6";
            BS_FE:   e = ".FE";
            BS_E0:   e = ".E0";
            BS_3F:   e = ".3F";
            BS_F4:   e = ".F4";
            BS_P2:   e = ".P2";
            BS_FA:   e = ".FA";
            BS_CV:   e = ".CV";
            default: e = 24'h0;
        endcase
        return e;
    endfunction

    // Fallback scheme when the extension says nothing useful.
    function automatic logic [3:0] size_to_bs(input size_t size);
        logic [3:0] bs;
        case (size)
            SIZE_8K:  bs = BS_F8;
            SIZE_12K: bs = BS_FA;
            SIZE_16K: bs = BS_F6;
            SIZE_32K: bs = BS_F4;
            default:  bs = BS_NONE;
        endcase
        return bs;
    endfunction

endpackage

// File: rtl/cart_ext_decode.sv
// Combinational lookup of a three-character file extension (".F8" etc.) to a
// bank-switch code; hit is low for anything not in the table (case sensitive).
module cart_ext_decode
    import a2600_cart_pkg::*;
(
    input  logic [23:0] ext,
    output logic        hit,
    output logic [3:0]  bs
);

    logic [NUM_BS-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BS; gi++) begin : g_match
            assign match[gi] = (ext == bs_ext(4'(gi + 1)));
        end
    endgenerate

    always_comb begin
        bs = BS_NONE;
        for (int i = 0; i < NUM_BS; i++) begin
            if (match[i]) begin
                bs = 4'(i + 1);
            end
        end
    end

    assign hit = |match;

endmodule

// File: rtl/cart_loader.sv
// Streams ioctl download bytes into the cartridge ROM, sizes the image, picks the
// bank-switch scheme and SuperChip enable, and publishes them together after the download.
module cart_loader
    import a2600_cart_pkg::*;
#(
    parameter int ROM_AW = 15,
    parameter int SIZE_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [31:0]       ioctl_file_ext,
    input  logic [1:0]        sc_mode,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [7:0]        rom_din,
    output logic [3:0]        force_bs,
    output logic              sc,
    output logic [SIZE_W-1:0] rom_size,
    output logic              cart_ready
);

    state_t state_reg, state_next;

    logic              dl_reg;
    logic              dl_rise;
    logic              dl_fall;
    logic              start_load;
    logic              publish;

    logic [31:0]       ext_reg;
    logic [SIZE_W-1:0] size_reg;
    logic              ovf_reg;
    logic              sc_fill_reg;
    logic              fill_ref_valid_reg;
    logic [7:0]        fill_ref_reg;

    logic              load_wr;
    logic              addr_in_range;
    logic              addr_in_rom;
    logic              fill_window;
    logic [SIZE_W-1:0] addr_end;

    logic [23:0]       ext_sel;
    logic              ext_hit;
    logic [3:0]        ext_bs;
    logic [3:0]        bs_pick;
    logic              sc_pick;

    assign dl_rise = ioctl_download & ~dl_reg;
    assign dl_fall = ~ioctl_download & dl_reg;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        start_load = 1'b0;
        publish    = 1'b0;
        case (state_reg)
            ST_IDLE, ST_READY: begin
                if (dl_rise) begin
                    state_next = ST_LOAD;
                    start_load = 1'b1;
                end
            end
            ST_LOAD: begin
                if (dl_fall) begin
                    state_next = ST_FINAL;
                end
            end
            ST_FINAL: begin
                publish    = 1'b1;
                state_next = ST_READY;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Writes are accepted throughout LOAD, including the cycle the download drops.
    assign load_wr       = (state_reg == ST_LOAD) & ioctl_wr;
    assign addr_in_range = (ioctl_addr[24:SIZE_W-1] == '0);
    assign addr_in_rom   = (ioctl_addr[24:ROM_AW] == '0);
    assign fill_window   = (ioctl_addr[11:7] == 5'd0);
    assign addr_end      = {1'b0, ioctl_addr[SIZE_W-2:0]} + SIZE_W'(1);

    // A right-aligned extension may be ".xx" in the low bytes or ".xxS" filling all four.
    assign ext_sel = (ext_reg[23:16] == ".") ? ext_reg[23:0] : ext_reg[31:8];

    cart_ext_decode u_ext_decode (
        .ext (ext_sel),
        .hit (ext_hit),
        .bs  (ext_bs)
    );

    assign bs_pick = ext_hit ? ext_bs : size_to_bs(size_t'(size_reg));

    always_comb begin
        case (sc_mode)
            2'd1:    sc_pick = 1'b0;
            2'd2,
            2'd3:    sc_pick = 1'b1;
            default: sc_pick = (ext_reg[7:0] == "S")
                             | (sc_fill_reg & (size_reg >= SIZE_W'(SC_MIN_SIZE)) & ~ovf_reg);
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_reg             <= 1'b0;
            rom_we             <= 1'b0;
            rom_addr           <= '0;
            rom_din            <= '0;
            ext_reg            <= '0;
            size_reg           <= '0;
            ovf_reg            <= 1'b0;
            sc_fill_reg        <= 1'b0;
            fill_ref_valid_reg <= 1'b0;
            fill_ref_reg       <= '0;
        end else begin
            dl_reg <= ioctl_download;
            rom_we <= 1'b0;
            if (start_load) begin
                ext_reg            <= ioctl_file_ext;
                size_reg           <= '0;
                ovf_reg            <= 1'b0;
                sc_fill_reg        <= 1'b1;
                fill_ref_valid_reg <= 1'b0;
            end
            if (load_wr) begin
                if (!addr_in_range) begin
                    ovf_reg <= 1'b1;
                end else begin
                    if (addr_in_rom) begin
                        rom_we   <= 1'b1;
                        rom_addr <= ioctl_addr[ROM_AW-1:0];
                        rom_din  <= ioctl_dout;
                    end
                    if (addr_end > size_reg) begin
                        size_reg <= addr_end;
                    end
                    // SuperChip images keep the first 128 bytes of each 4K bank uniform.
                    if (fill_window) begin
                        if (ioctl_addr[6:0] == 7'd0) begin
                            fill_ref_reg       <= ioctl_dout;
                            fill_ref_valid_reg <= 1'b1;
                        end else if (fill_ref_valid_reg && (ioctl_dout != fill_ref_reg)) begin
                            sc_fill_reg <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            force_bs   <= BS_NONE;
            sc         <= 1'b0;
            rom_size   <= '0;
            cart_ready <= 1'b0;
        end else begin
            if (start_load) begin
                cart_ready <= 1'b0;
            end
            if (publish) begin
                force_bs   <= bs_pick;
                sc         <= sc_pick;
                rom_size   <= size_reg;
                cart_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: a table of directed images plus randomized images checked
// against a behavioural model of the sizing / scheme / SuperChip rules.
module tb_cart_loader;

    logic        clk;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [31:0] ioctl_file_ext;
    logic [1:0]  sc_mode;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [7:0]  rom_din;
    logic [3:0]  force_bs;
    logic        sc;
    logic [16:0] rom_size;
    logic        cart_ready;

    cart_loader dut (
        .clk_sys        (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_file_ext (ioctl_file_ext),
        .sc_mode        (sc_mode),
        .rom_we         (rom_we),
        .rom_addr       (rom_addr),
        .rom_din        (rom_din),
        .force_bs       (force_bs),
        .sc             (sc),
        .rom_size       (rom_size),
        .cart_ready     (cart_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  img [65536];
    int          addr_q [$];
    logic [22:0] exp_q [$];
    logic [22:0] mon_w;

    logic [3:0]  prev_bs;
    logic        prev_sc;
    int          prev_size;

    typedef struct {
        int          len;
        logic [31:0] fext;
        logic [1:0]  mode;
        int          fill;
        logic [3:0]  bs;
        logic        sc;
        int          size;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every ROM write must match the next byte the bench sent below 32K, in order.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rom_write_unexpected: got addr %0h data %0h expected no write", rom_addr, rom_din);
            end else begin
                mon_w = exp_q.pop_front();
                if ({rom_addr, rom_din} !== mon_w) begin
                    n_bad++;
                    $display("FAIL rom_write: got %0h/%0h expected %0h/%0h",
                             rom_addr, rom_din, mon_w[22:8], mon_w[7:0]);
                end
            end
        end
    end

    // fill: 0 random (bank-0 window non-uniform), 1 windows all 0xFF, 2 as 1 with one 0x00.
    task automatic build(input int len, input int fill, input bit dense);
        bit win;
        addr_q.delete();
        for (int a = 0; a < len; a++) begin
            win = (a % 4096) < 128;
            img[a] = 8'($urandom);
            if (fill != 0 && win) img[a] = 8'hFF;
            if (dense || len <= 4096 || win || (a % 61) == 0 || a == len - 1) addr_q.push_back(a);
        end
        if (fill == 0 && len > 1) img[1] = img[0] ^ 8'h5A;
        if (fill == 2) img[(len > 4133) ? 4133 : 37] = 8'h00;
    endtask

    function automatic logic [3:0] ext_lookup(input logic [23:0] e);
        case (e)
            ".F8":   return 4'd1;
            ".F6":   return 4'd2;
            ".FE":   return 4'd3;
            ".E0":   return 4'd4;
            ".3F":   return 4'd5;
            ".F4":   return 4'd6;
            ".P2":   return 4'd7;
            ".FA":   return 4'd8;
            ".CV":   return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic void model(input logic [31:0] fext, input logic [1:0] mode,
                                  output logic [3:0] bs, output logic scv, output int size);
        bit ovf;
        bit fill_ok;
        int a;
        logic [23:0] e;
        ovf = 0;
        fill_ok = 1;
        size = 0;
        foreach (addr_q[i]) begin
            a = addr_q[i];
            if (a >= 65536) begin
                ovf = 1;
            end else begin
                if (a + 1 > size) size = a + 1;
                if ((a % 4096) < 128 && img[a] != img[a - (a % 128)]) fill_ok = 0;
            end
        end
        e = (fext[23:16] == ".") ? fext[23:0] : fext[31:8];
        bs = ext_lookup(e);
        if (bs == 4'd0) begin
            case (size)
                8192:    bs = 4'd1;
                12288:   bs = 4'd8;
                16384:   bs = 4'd2;
                32768:   bs = 4'd6;
                default: bs = 4'd0;
            endcase
        end
        if (mode == 2'd1)      scv = 1'b0;
        else if (mode >= 2'd2) scv = 1'b1;
        else                   scv = (fext[7:0] == "S") || (fill_ok && size >= 8192 && !ovf);
    endfunction

    task automatic drive_byte(input int a);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = (a < 65536) ? img[a] : 8'hA5;
        if (a < 32768) exp_q.push_back({15'(a), ioctl_dout});
    endtask

    task automatic run_load(input string tag, input logic [31:0] fext, input logic [1:0] mode,
                            input logic [3:0] e_bs, input logic e_sc, input int e_size);
        int n;
        n = addr_q.size();
        ioctl_file_ext = fext;
        sc_mode        = mode;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == n / 2) begin
                chk({tag, "_hold_bs"},    32'(force_bs),   32'(prev_bs));
                chk({tag, "_hold_sc"},    32'(sc),         32'(prev_sc));
                chk({tag, "_hold_size"},  32'(rom_size),   32'(prev_size));
                chk({tag, "_hold_ready"}, 32'(cart_ready), 32'd0);
            end
            drive_byte(addr_q[i]);
            if (i == n - 1) ioctl_download = 1'b0;
            @(negedge clk);
        end
        ioctl_wr = 1'b0;
        if (n == 0) begin
            ioctl_download = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_ready_early"}, 32'(cart_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_ready"},   32'(cart_ready), 32'd1);
        chk({tag, "_bs"},      32'(force_bs),   32'(e_bs));
        chk({tag, "_sc"},      32'(sc),         32'(e_sc));
        chk({tag, "_size"},    32'(rom_size),   32'(e_size));
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        $display("load %s ext=%s mode=%0d bytes=%0d -> bs=%0d sc=%0b size=%0d",
                 tag, fext, mode, n, force_bs, sc, rom_size);
        prev_bs   = e_bs;
        prev_sc   = e_sc;
        prev_size = e_size;
    endtask

    int          lens [7]  = '{1, 4096, 8192, 10000, 12288, 32768, 65536};
    logic [31:0] exts [8]  = '{".BIN", ".F8S", ".E0", ".3F", ".CV", ".P2S", ".FA", ".f6"};

    initial begin
        logic [3:0]  m_bs;
        logic        m_sc;
        int          m_size;
        logic [31:0] r_ext;
        logic [1:0]  r_mode;

        vecs[0] = '{4096,  ".BIN", 2'd0, 0, 4'd0, 1'b0, 4096};
        vecs[1] = '{8192,  ".F8S", 2'd0, 0, 4'd1, 1'b1, 8192};
        vecs[2] = '{8192,  ".F8S", 2'd1, 0, 4'd1, 1'b0, 8192};
        vecs[3] = '{16384, ".BIN", 2'd0, 1, 4'd2, 1'b1, 16384};
        vecs[4] = '{16384, ".BIN", 2'd0, 2, 4'd2, 1'b0, 16384};
        vecs[5] = '{40960, ".BIN", 2'd0, 0, 4'd0, 1'b0, 40960};
        vecs[6] = '{0,     ".BIN", 2'd2, 0, 4'd0, 1'b1, 0};
        vecs[7] = '{12288, ".bin", 2'd0, 1, 4'd8, 1'b1, 12288};
        vecs[8] = '{32768, ".3F",  2'd3, 0, 4'd5, 1'b1, 32768};
        vecs[9] = '{8192,  ".f8",  2'd0, 0, 4'd1, 1'b0, 8192};

        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        ioctl_file_ext = '0;
        sc_mode = 2'd0;
        prev_bs = 4'd0;
        prev_sc = 1'b0;
        prev_size = 0;
        repeat (3) @(negedge clk);
        chk("reset_we",    32'(rom_we),     32'd0);
        chk("reset_bs",    32'(force_bs),   32'd0);
        chk("reset_sc",    32'(sc),         32'd0);
        chk("reset_size",  32'(rom_size),   32'd0);
        chk("reset_ready", 32'(cart_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            build(vecs[v].len, vecs[v].fill, 1'b0);
            run_load($sformatf("vec%0d", v), vecs[v].fext, vecs[v].mode,
                     vecs[v].bs, vecs[v].sc, vecs[v].size);
        end

        // Reset in the middle of a dense download.
        build(8192, 0, 1'b1);
        ioctl_file_ext = ".E0";
        sc_mode = 2'd0;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            drive_byte(addr_q[i]);
            @(negedge clk);
        end
        ioctl_wr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        ioctl_download = 1'b0;
        #1;
        chk("abort_ready",   32'(cart_ready), 32'd0);
        chk("abort_size",    32'(rom_size),   32'd0);
        chk("abort_bs",      32'(force_bs),   32'd0);
        chk("abort_we",      32'(rom_we),     32'd0);
        chk("abort_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1;
            ioctl_addr = 25'(100 + i);
            ioctl_dout = 8'h3C;
            @(negedge clk);
            chk("idle_no_we", 32'(rom_we), 32'd0);
        end
        ioctl_wr = 1'b0;
        chk("idle_ready", 32'(cart_ready), 32'd0);
        $display("abort after 2000 bytes -> ready=%0b size=%0d", cart_ready, rom_size);
        prev_bs = 4'd0;
        prev_sc = 1'b0;
        prev_size = 0;

        build(8192, 0, 1'b0);
        run_load("after_abort", ".E0", 2'd0, 4'd4, 1'b0, 8192);

        // Back-to-back: second load must hold the first image's outputs until its FINAL.
        build(4096, 0, 1'b0);
        run_load("b2b_first", ".CV", 2'd2, 4'd9, 1'b1, 4096);
        build(8192, 1, 1'b0);
        run_load("b2b_second", ".FE", 2'd1, 4'd3, 1'b0, 8192);

        for (int r = 0; r < 6; r++) begin
            build(lens[$urandom_range(0, 6)], int'($urandom_range(0, 2)), 1'b0);
            if ($urandom_range(0, 2) == 0) addr_q.insert(1, 65536 + int'($urandom_range(0, 1000)));
            r_ext  = exts[$urandom_range(0, 7)];
            r_mode = 2'($urandom_range(0, 3));
            model(r_ext, r_mode, m_bs, m_sc, m_size);
            run_load($sformatf("rand%0d", r), r_ext, r_mode, m_bs, m_sc, m_size);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
